// File: rtl/uart_rx_cfg_if.sv
// Signal bundle around one uart_rx_cfg receiver: tick enable and serial line in,
// frame status and received word out.
interface uart_rx_cfg_if #(
    parameter int WIDTH_WORD = 8
);
    logic                  rate;
    logic                  bit_rx;
    logic                  rx_done;
    logic [WIDTH_WORD-1:0] data_out;
    logic                  parity_error;
    logic                  frame_error;
    logic                  busy;

    modport master (
        output rate, bit_rx,
        input  rx_done, data_out, parity_error, frame_error, busy
    );

    modport slave (
        input  rate, bit_rx,
        output rx_done, data_out, parity_error, frame_error, busy
    );
endinterface

// File: rtl/uart_rx_cfg.sv
// Oversampling UART receiver with configurable word width, stop bits, parity and
// bit order; each bit is the majority of the last three ticks of its period.
module uart_rx_cfg #(
    parameter int WIDTH_WORD    = 8,
    parameter int CANT_BIT_STOP = 2,
    parameter int OVERSAMPLE    = 16,
    parameter int PARITY_MODE   = 0,
    parameter int MSB_FIRST     = 1
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_rate,
    input  logic                  i_bit_rx,
    output logic                  o_rx_done,
    output logic [WIDTH_WORD-1:0] o_data_out,
    output logic                  o_parity_error,
    output logic                  o_frame_error,
    output logic                  o_busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(WIDTH_WORD) + 1;

    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_S0   = TW'(OVERSAMPLE - 3);
    localparam logic [TW-1:0] TICK_S1   = TW'(OVERSAMPLE - 2);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_DATA = BW'(WIDTH_WORD - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(CANT_BIT_STOP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_RECOVER
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            sync_q, sync_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [WIDTH_WORD-1:0] shift_q, shift_d;
    logic [1:0]            maj_q, maj_d;
    logic                  perr_pend_q, perr_pend_d;
    logic                  ferr_pend_q, ferr_pend_d;
    logic                  done_q, done_d;
    logic [WIDTH_WORD-1:0] data_q, data_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;

    logic line;
    logic bit_sample;
    logic ferr_now;

    assign line       = sync_q[1];
    assign bit_sample = (maj_q[0] & maj_q[1]) | (maj_q[0] & line) | (maj_q[1] & line);
    assign ferr_now   = ferr_pend_q | ~bit_sample;

    always_comb begin
        // NOTE: every _d starts from its _q (done from 0) so no branch can leave one unassigned and infer a latch.
        state_d     = state_q;
        sync_d      = {sync_q[0], i_bit_rx};
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        maj_d       = maj_q;
        perr_pend_d = perr_pend_q;
        ferr_pend_d = ferr_pend_q;
        done_d      = 1'b0;
        data_d      = data_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;

        if (i_rate) begin
            if (tick_q == TICK_S0) maj_d[0] = line;
            if (tick_q == TICK_S1) maj_d[1] = line;

            unique case (state_q)
                S_IDLE: begin
                    tick_d = '0;
                    if (!line) state_d = S_START;
                end
                S_START: begin
                    if (tick_q == TICK_MID) begin
                        tick_d = '0;
                        bit_d  = '0;
                        if (!line) begin
                            state_d     = S_DATA;
                            perr_pend_d = 1'b0;
                            ferr_pend_d = 1'b0;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                S_DATA, S_PARITY, S_STOP: begin
                    if (tick_q != TICK_LAST) begin
                        tick_d = tick_q + 1'b1;
                    end else begin
                        tick_d = '0;
                        if (state_q == S_DATA) begin
                            if (MSB_FIRST != 0) shift_d = {shift_q[WIDTH_WORD-2:0], bit_sample};
                            else                shift_d = {bit_sample, shift_q[WIDTH_WORD-1:1]};
                            if (bit_q == LAST_DATA) begin
                                bit_d   = '0;
                                state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                            end else begin
                                bit_d = bit_q + 1'b1;
                            end
                        end else if (state_q == S_PARITY) begin
                            perr_pend_d = (^shift_q) ^ bit_sample ^ (PARITY_MODE == 2);
                            state_d     = S_STOP;
                        end else begin
                            ferr_pend_d = ferr_now;
                            if (bit_q == LAST_STOP) begin
                                // Publish the frame, including any errors, in one cycle.
                                bit_d   = '0;
                                done_d  = 1'b1;
                                data_d  = shift_q;
                                perr_d  = perr_pend_q;
                                ferr_d  = ferr_now;
                                state_d = ferr_now ? S_RECOVER : S_IDLE;
                            end else begin
                                bit_d = bit_q + 1'b1;
                            end
                        end
                    end
                end
                S_RECOVER: begin
                    tick_d = '0;
                    if (line) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q     <= S_IDLE;
            sync_q      <= 2'b11;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            maj_q       <= '0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            done_q      <= 1'b0;
            data_q      <= '0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every flop samples pre-edge values regardless of statement order.
            state_q     <= state_d;
            sync_q      <= sync_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            maj_q       <= maj_d;
            perr_pend_q <= perr_pend_d;
            ferr_pend_q <= ferr_pend_d;
            done_q      <= done_d;
            data_q      <= data_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
        end
    end

    assign o_rx_done      = done_q;
    assign o_data_out     = data_q;
    assign o_parity_error = perr_q;
    assign o_frame_error  = ferr_q;
    assign o_busy         = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Directed bench for uart_rx_cfg: three receivers in different configurations share
// clock, reset and tick; only the selected one sees serial stimulus.
module tb_uart_rx_cfg;
    logic clk;
    logic rst_n;
    int   sel;
    int   tests_run;
    int   tests_failed;
    int   done_cnt0, done_cnt1, done_cnt2;

    uart_rx_cfg_if #(.WIDTH_WORD(8)) bus0 ();
    uart_rx_cfg_if #(.WIDTH_WORD(8)) bus1 ();
    uart_rx_cfg_if #(.WIDTH_WORD(7)) bus2 ();

    uart_rx_cfg u_dut0 (
        .i_clock(clk), .i_reset(rst_n), .i_rate(bus0.rate), .i_bit_rx(bus0.bit_rx),
        .o_rx_done(bus0.rx_done), .o_data_out(bus0.data_out),
        .o_parity_error(bus0.parity_error), .o_frame_error(bus0.frame_error), .o_busy(bus0.busy)
    );

    uart_rx_cfg #(.PARITY_MODE(1)) u_dut1 (
        .i_clock(clk), .i_reset(rst_n), .i_rate(bus1.rate), .i_bit_rx(bus1.bit_rx),
        .o_rx_done(bus1.rx_done), .o_data_out(bus1.data_out),
        .o_parity_error(bus1.parity_error), .o_frame_error(bus1.frame_error), .o_busy(bus1.busy)
    );

    uart_rx_cfg #(.WIDTH_WORD(7), .MSB_FIRST(0), .CANT_BIT_STOP(1)) u_dut2 (
        .i_clock(clk), .i_reset(rst_n), .i_rate(bus2.rate), .i_bit_rx(bus2.bit_rx),
        .o_rx_done(bus2.rx_done), .o_data_out(bus2.data_out),
        .o_parity_error(bus2.parity_error), .o_frame_error(bus2.frame_error), .o_busy(bus2.busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts high cycles of each rx_done, so a stretched pulse shows as more than one.
    always @(negedge clk) begin
        if (bus0.rx_done === 1'b1) done_cnt0++;
        if (bus1.rx_done === 1'b1) done_cnt1++;
        if (bus2.rx_done === 1'b1) done_cnt2++;
    end

    // One oversampling tick: the line value settles through the synchronizer first.
    task automatic tick(input logic v);
        bus0.bit_rx = (sel == 0) ? v : 1'b1;
        bus1.bit_rx = (sel == 1) ? v : 1'b1;
        bus2.bit_rx = (sel == 2) ? v : 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        bus0.rate = 1'b1; bus1.rate = 1'b1; bus2.rate = 1'b1;
        @(posedge clk);
        #1;
        bus0.rate = 1'b0; bus1.rate = 1'b0; bus2.rate = 1'b0;
    endtask

    task automatic send_bit(input logic v, input int n);
        repeat (n) tick(v);
    endtask

    // 8-bit MSB-first frame with two stop bits, optional parity bit.
    task automatic send_frame8(input logic [7:0] data, input bit with_par, input logic par);
        send_bit(1'b0, 16);
        for (int i = 7; i >= 0; i--) send_bit(data[i], 16);
        if (with_par) send_bit(par, 16);
        send_bit(1'b1, 16);
        send_bit(1'b1, 16);
    endtask

    task automatic test_reset();
        tests_run++;
        if (bus0.rx_done !== 1'b0) begin tests_failed++; $display("FAIL reset_done: got %b expected 0", bus0.rx_done); end
        tests_run++;
        if (bus0.data_out !== 8'h00) begin tests_failed++; $display("FAIL reset_data: got %h expected 00", bus0.data_out); end
        tests_run++;
        if (bus0.parity_error !== 1'b0) begin tests_failed++; $display("FAIL reset_perr: got %b expected 0", bus0.parity_error); end
        tests_run++;
        if (bus0.frame_error !== 1'b0) begin tests_failed++; $display("FAIL reset_ferr: got %b expected 0", bus0.frame_error); end
        tests_run++;
        if (bus0.busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b expected 0", bus0.busy); end
        tests_run++;
        if (bus2.data_out !== 7'h00) begin tests_failed++; $display("FAIL reset_data2: got %h expected 00", bus2.data_out); end
    endtask

    task automatic test_basic();
        int base;
        sel  = 0;
        send_bit(1'b1, 4);
        base = done_cnt0;
        send_frame8(8'hA5, 1'b0, 1'b0);
        tests_run++;
        if (done_cnt0 - base != 1) begin tests_failed++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt0 - base); end
        tests_run++;
        if (bus0.data_out !== 8'hA5) begin tests_failed++; $display("FAIL basic_data: got %h expected a5", bus0.data_out); end
        tests_run++;
        if (bus0.parity_error !== 1'b0) begin tests_failed++; $display("FAIL basic_perr: got %b expected 0", bus0.parity_error); end
        tests_run++;
        if (bus0.frame_error !== 1'b0) begin tests_failed++; $display("FAIL basic_ferr: got %b expected 0", bus0.frame_error); end
        tests_run++;
        if (bus0.busy !== 1'b0) begin tests_failed++; $display("FAIL basic_busy: got %b expected 0", bus0.busy); end
    endtask

    task automatic test_false_start();
        int base;
        sel  = 0;
        base = done_cnt0;
        send_bit(1'b0, 4);
        tests_run++;
        if (bus0.busy !== 1'b1) begin tests_failed++; $display("FAIL false_start_busy_hi: got %b expected 1", bus0.busy); end
        send_bit(1'b1, 8);
        tests_run++;
        if (bus0.busy !== 1'b0) begin tests_failed++; $display("FAIL false_start_busy_lo: got %b expected 0", bus0.busy); end
        tests_run++;
        if (done_cnt0 != base) begin tests_failed++; $display("FAIL false_start_done: got %0d pulses expected 0", done_cnt0 - base); end
        tests_run++;
        if (bus0.data_out !== 8'hA5) begin tests_failed++; $display("FAIL false_start_data_hold: got %h expected a5", bus0.data_out); end
    endtask

    task automatic test_parity();
        int base;
        sel  = 1;
        send_bit(1'b1, 4);
        base = done_cnt1;
        send_frame8(8'h0F, 1'b1, 1'b1);
        tests_run++;
        if (bus1.parity_error !== 1'b1) begin tests_failed++; $display("FAIL parity_bad_perr: got %b expected 1", bus1.parity_error); end
        tests_run++;
        if (bus1.data_out !== 8'h0F) begin tests_failed++; $display("FAIL parity_bad_data: got %h expected 0f", bus1.data_out); end
        tests_run++;
        if (bus1.frame_error !== 1'b0) begin tests_failed++; $display("FAIL parity_bad_ferr: got %b expected 0", bus1.frame_error); end
        send_frame8(8'h0F, 1'b1, 1'b0);
        tests_run++;
        if (bus1.parity_error !== 1'b0) begin tests_failed++; $display("FAIL parity_good_perr: got %b expected 0", bus1.parity_error); end
        tests_run++;
        if (done_cnt1 - base != 2) begin tests_failed++; $display("FAIL parity_done_pulses: got %0d expected 2", done_cnt1 - base); end
    endtask

    task automatic test_glitch_lsb_first();
        int base;
        sel  = 2;
        send_bit(1'b1, 4);
        base = done_cnt2;
        send_bit(1'b0, 16);
        // First data bit is 1 with a single low tick at its second majority sample.
        send_bit(1'b1, 7);
        send_bit(1'b0, 1);
        send_bit(1'b1, 8);
        send_bit(1'b0, 16 * 6);
        send_bit(1'b1, 16);
        tests_run++;
        if (bus2.data_out !== 7'h01) begin tests_failed++; $display("FAIL glitch_data: got %h expected 01", bus2.data_out); end
        tests_run++;
        if (done_cnt2 - base != 1) begin tests_failed++; $display("FAIL glitch_done_pulses: got %0d expected 1", done_cnt2 - base); end
        tests_run++;
        if (bus2.parity_error !== 1'b0 || bus2.frame_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch_flags: got perr=%b ferr=%b expected 0/0", bus2.parity_error, bus2.frame_error);
        end
    endtask

    task automatic test_frame_error();
        int base;
        sel  = 0;
        send_bit(1'b1, 4);
        base = done_cnt0;
        send_bit(1'b0, 16);
        for (int i = 7; i >= 0; i--) send_bit(logic'(i % 2 == 0), 16);
        send_bit(1'b1, 16);
        send_bit(1'b0, 40);
        tests_run++;
        if (bus0.frame_error !== 1'b1) begin tests_failed++; $display("FAIL ferr_flag: got %b expected 1", bus0.frame_error); end
        tests_run++;
        if (bus0.data_out !== 8'h55) begin tests_failed++; $display("FAIL ferr_data: got %h expected 55", bus0.data_out); end
        tests_run++;
        if (bus0.busy !== 1'b1) begin tests_failed++; $display("FAIL ferr_recover_busy: got %b expected 1", bus0.busy); end
        tests_run++;
        if (done_cnt0 - base != 1) begin tests_failed++; $display("FAIL ferr_done_pulses: got %0d expected 1", done_cnt0 - base); end
        send_bit(1'b1, 1);
        tests_run++;
        if (bus0.busy !== 1'b0) begin tests_failed++; $display("FAIL ferr_back_idle: got busy=%b expected 0", bus0.busy); end
        send_bit(1'b1, 3);
        send_frame8(8'h3C, 1'b0, 1'b0);
        tests_run++;
        if (bus0.data_out !== 8'h3C) begin tests_failed++; $display("FAIL ferr_next_data: got %h expected 3c", bus0.data_out); end
        tests_run++;
        if (bus0.frame_error !== 1'b0) begin tests_failed++; $display("FAIL ferr_next_flag: got %b expected 0", bus0.frame_error); end
    endtask

    task automatic test_back_to_back();
        int base;
        sel  = 0;
        base = done_cnt0;
        send_frame8(8'hC3, 1'b0, 1'b0);
        send_frame8(8'h5A, 1'b0, 1'b0);
        tests_run++;
        if (bus0.data_out !== 8'h5A) begin tests_failed++; $display("FAIL b2b_data: got %h expected 5a", bus0.data_out); end
        tests_run++;
        if (done_cnt0 - base != 2) begin tests_failed++; $display("FAIL b2b_done_pulses: got %0d expected 2", done_cnt0 - base); end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        logic [7:0] partial;
        sel     = 0;
        partial = 8'h96;
        send_bit(1'b1, 4);
        base = done_cnt0;
        send_bit(1'b0, 16);
        for (int i = 7; i >= 4; i--) send_bit(partial[i], 16);
        send_bit(partial[3], 8);
        rst_n = 1'b0;
        #2;
        tests_run++;
        if (bus0.data_out !== 8'h00) begin tests_failed++; $display("FAIL midrst_data: got %h expected 00", bus0.data_out); end
        tests_run++;
        if (bus0.busy !== 1'b0) begin tests_failed++; $display("FAIL midrst_busy: got %b expected 0", bus0.busy); end
        tests_run++;
        if (bus0.rx_done !== 1'b0 || bus0.parity_error !== 1'b0 || bus0.frame_error !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrst_flags: got done=%b perr=%b ferr=%b expected 0/0/0",
                     bus0.rx_done, bus0.parity_error, bus0.frame_error);
        end
        tests_run++;
        if (done_cnt0 != base) begin tests_failed++; $display("FAIL midrst_no_done: got %0d pulses expected 0", done_cnt0 - base); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        send_bit(1'b1, 20);
        send_frame8(8'h81, 1'b0, 1'b0);
        tests_run++;
        if (bus0.data_out !== 8'h81) begin tests_failed++; $display("FAIL midrst_next_data: got %h expected 81", bus0.data_out); end
        tests_run++;
        if (done_cnt0 - base != 1) begin tests_failed++; $display("FAIL midrst_next_pulses: got %0d expected 1", done_cnt0 - base); end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        done_cnt0    = 0;
        done_cnt1    = 0;
        done_cnt2    = 0;
        sel          = 0;
        rst_n        = 1'b0;
        bus0.rate = 1'b0; bus1.rate = 1'b0; bus2.rate = 1'b0;
        bus0.bit_rx = 1'b1; bus1.bit_rx = 1'b1; bus2.bit_rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_basic();
        test_false_start();
        test_parity();
        test_glitch_lsb_first();
        test_frame_error();
        test_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
UART_RX_CFG -- requirements
Module: uart_rx_cfg

Interface
REQ-001 The module SHALL have parameter WIDTH_WORD, default 8, meaning data bits per frame, legal range 5..9.
REQ-002 The module SHALL have parameter CANT_BIT_STOP, default 2, meaning stop bits per frame, legal range 1..2.
REQ-003 The module SHALL have parameter OVERSAMPLE, default 16, meaning i_rate ticks per bit, legal values 8 or 16.
REQ-004 The module SHALL have parameter PARITY_MODE, default 0, meaning 0 = none, 1 = even, 2 = odd.
REQ-005 The module SHALL have parameter MSB_FIRST, default 1, meaning 1 = first data bit lands in the MSB and 0 = first data bit lands in the LSB.
REQ-006 The module SHALL have port i_clock, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-007 The module SHALL have port i_reset, input, 1 bit: asynchronous, active-low reset.
REQ-008 The module SHALL have port i_rate, input, 1 bit: oversampling tick enable, one i_clock cycle wide.
REQ-009 The module SHALL have port i_bit_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-010 The module SHALL have port o_rx_done, output, 1 bit: one-clock pulse marking frame completion.
REQ-011 The module SHALL have port o_data_out, output, WIDTH_WORD bits: last received word.
REQ-012 The module SHALL have port o_parity_error, output, 1 bit: parity mismatch on the last frame.
REQ-013 The module SHALL have port o_frame_error, output, 1 bit: a stop bit of the last frame was sampled 0.
REQ-014 The module SHALL have port o_busy, output, 1 bit: high in every state except IDLE.

Function
REQ-015 i_bit_rx SHALL pass through a 2-flop synchronizer (reset value 1) before any use; all references to "line" mean the synchronized value.
REQ-016 The state machine SHALL advance and count only on clocks where i_rate=1; on all other clocks the state and counters hold.
REQ-017 The states SHALL be IDLE, START, DATA, PARITY, STOP and RECOVER.
REQ-018 IDLE: line=0 on a tick SHALL cause a transition to START with the tick counter cleared.
REQ-019 START: at tick count OVERSAMPLE/2-1 the line SHALL be rechecked; 0 -> DATA with counter cleared, 1 -> IDLE (false start, no flags, no o_rx_done).
REQ-020 Each bit period SHALL span OVERSAMPLE ticks, counted 0..OVERSAMPLE-1, and the bit value SHALL be the majority of the line at counts OVERSAMPLE-3, OVERSAMPLE-2 and OVERSAMPLE-1.
REQ-021 DATA: WIDTH_WORD bits SHALL be shifted in per MSB_FIRST; after the last bit the next state SHALL be PARITY if PARITY_MODE≠0, else STOP.
REQ-022 PARITY: one bit SHALL be sampled; the error is the XOR of the data bits and the parity bit, inverted for odd parity.
REQ-023 STOP: CANT_BIT_STOP bits SHALL be sampled; any 0 SHALL set the pending frame error.
REQ-024 After the last stop sample the next state SHALL be IDLE if no frame error occurred, else RECOVER.
REQ-025 RECOVER SHALL remain until the line is 1 on a tick, then go to IDLE.
REQ-026 On the clock after the i_rate cycle that samples the last stop bit, o_rx_done SHALL pulse high for exactly one i_clock cycle, and o_data_out, o_parity_error and o_frame_error SHALL update simultaneously.
REQ-027 o_data_out and both error flags SHALL be updated even when an error occurs, and SHALL hold until the next o_rx_done.
REQ-028 o_parity_error SHALL be 0 whenever PARITY_MODE=0.
REQ-029 A new start bit SHALL be detectable on the first tick after returning to IDLE (back-to-back frames).
REQ-030 Tick counters SHALL be sized $clog2(OVERSAMPLE) bits and the bit counter $clog2(WIDTH_WORD)+1 bits, with no wrap inside a frame.

Reset
REQ-031 Asserting i_reset=0 SHALL immediately, without a clock, force state IDLE, all counters and the shift buffer to 0, the synchronizer flops to 1, o_rx_done, o_parity_error, o_frame_error and o_busy to 0, and o_data_out to 0.
REQ-032 Reset asserted mid-frame SHALL abort the frame with no o_rx_done; after release the module SHALL wait in IDLE for a new falling edge.

Verification
REQ-033 Defaults, frame 0xA5 MSB-first with 2 stop bits -> exactly one o_rx_done pulse, o_data_out=0xA5, both error flags 0.
REQ-034 PARITY_MODE=1, data 0x0F with parity bit 1 -> o_parity_error=1, o_data_out=0x0F; a second frame with parity bit 0 -> o_parity_error=0.
REQ-035 Line low for 4 ticks, then high -> return to IDLE, no o_rx_done, o_busy falls.
REQ-036 Second stop bit sent as 0 with the line held low 40 ticks -> o_frame_error=1, module stays in RECOVER until the line is high, then a following frame 0x3C is received cleanly.
REQ-037 A one-tick 0 glitch at count OVERSAMPLE-2 inside a 1 data bit -> the bit is still received as 1; with MSB_FIRST=0, WIDTH_WORD=7 and serial bits 1,0,0,0,0,0,0 -> o_data_out=0x01.
REQ-038 i_reset pulsed low during bit 4 -> all outputs 0 asynchronously; the next full frame 0x81 is received correctly.
